// File: rtl/gpio_hex_display_pkg.sv
// Shared types and constants for the GPIO hex display: scan states, blank code,
// and the active-low hex segment table (bit 6..0 = g..a).
package gpio_disp_pkg;

    typedef enum logic {
        SCAN = 1'b0,
        GAP  = 1'b1
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the pattern for nibble n; listed high-to-low in the concatenation
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // True when digit d lies above the most significant nonzero nibble of v
    function automatic logic lead_zero(input logic [31:0] v, input logic [2:0] d);
        return (d != 3'd0) && ((v >> {d, 2'b00}) == 32'd0);
    endfunction

endpackage

// File: rtl/gpio_hex_display_if.sv
// Bundle between the CPU gpio_out side (master) and the display block (slave).
interface gpio_hex_display_if;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_done;

    modport master (output value, dp_mask, input seg, dp, an, frame_done);
    modport slave  (input value, dp_mask, output seg, dp, an, frame_done);
endinterface

// File: rtl/gpio_hex_display_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
import gpio_disp_pkg::*;

module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb seg = HEX_SEG[nibble];
endmodule

// File: rtl/gpio_hex_display.sv
// Eight-digit multiplexed hex display with frame-consistent shadow registers.
// Optional leading-zero blanking is enabled by defining GPIO_DISP_LZB_EN.
import gpio_disp_pkg::*;

module gpio_hex_display #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned GAP_CYC  = 16
) (
    input  logic clk,
    input  logic rst,
    gpio_hex_display_if.slave bus
);
    localparam int unsigned MAX_CYC  = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : ((GAP_CYC > 1) ? GAP_CYC : 1);
    localparam int unsigned CW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned GAP_LIMIT = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LIMIT);

    disp_state_t   state, state_n;
    logic [2:0]    dig, dig_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   shadow_val, shadow_val_n;
    logic [7:0]    shadow_dp, shadow_dp_n;
    logic          advance, wrap;

    logic [6:0]    seg_q, seg_n, dec_seg;
    logic [7:0]    an_q, an_n;
    logic          dp_q, dp_n, fd_q;
    logic [3:0]    nibble_n;

    always_comb begin
        state_n      = state;
        dig_n        = dig;
        cnt_n        = cnt + CW'(1);
        shadow_val_n = shadow_val;
        shadow_dp_n  = shadow_dp;
        advance      = 1'b0;
        wrap         = 1'b0;

        case (state)
            SCAN: if (cnt == SCAN_LAST) begin
                cnt_n = '0;
                if (GAP_CYC > 0) state_n = GAP;
                else             advance = 1'b1;
            end
            GAP: if (cnt == GAP_LAST) begin
                cnt_n   = '0;
                advance = 1'b1;
            end
            default: state_n = SCAN;
        endcase

        if (advance) begin
            state_n = SCAN;
            dig_n   = dig + 3'd1;
            if (dig == 3'd7) begin
                wrap         = 1'b1;
                shadow_val_n = bus.value;
                shadow_dp_n  = bus.dp_mask;
            end
        end
    end

    // Decoder sees next-state data so outputs move on the same edge as the state
    assign nibble_n = shadow_val_n[{dig_n, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble_n),
        .seg    (dec_seg)
    );

    always_comb begin
        an_n  = 8'hFF;
        seg_n = SEG_BLANK;
        dp_n  = 1'b1;
        if (state_n == SCAN) begin
            an_n = ~(8'd1 << dig_n);
`ifdef GPIO_DISP_LZB_EN
            seg_n = lead_zero(shadow_val_n, dig_n) ? SEG_BLANK : dec_seg;
`else
            seg_n = dec_seg;
`endif
            dp_n = ~shadow_dp_n[dig_n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCAN;
            dig        <= '0;
            cnt        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            an_q       <= 8'hFE;
            seg_q      <= HEX_SEG[0];
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            state      <= state_n;
            dig        <= dig_n;
            cnt        <= cnt_n;
            shadow_val <= shadow_val_n;
            shadow_dp  <= shadow_dp_n;
            an_q       <= an_n;
            seg_q      <= seg_n;
            dp_q       <= dp_n;
            fd_q       <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Directed bench for gpio_hex_display: a frame-timing model fills a scoreboard each cycle.
// Two instances: SCAN_DIV=4/GAP_CYC=1 (F=40) and SCAN_DIV=4/GAP_CYC=0 (F=32).
module tb_gpio_hex_display;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned k = 0;
    logic [31:0] sv1 = '0, sv0 = '0;
    logic [7:0]  sd1 = '0, sd0 = '0;
    obs_t        q1[$];
    obs_t        q0[$];

    always #5 clk = ~clk;

    gpio_hex_display_if bus1 ();
    gpio_hex_display_if bus0 ();

    assign bus1.value   = value;
    assign bus1.dp_mask = dp_mask;
    assign bus0.value   = value;
    assign bus0.dp_mask = dp_mask;

    gpio_hex_display #(.SCAN_DIV(4), .GAP_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    gpio_hex_display #(.SCAN_DIV(4), .GAP_CYC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Expected outputs for cycle kk after reset release, from the frame timing rules
    function automatic obs_t model(int unsigned kk, int unsigned s, int unsigned g,
                                   logic [31:0] sv, logic [7:0] sd);
        obs_t        o;
        int unsigned per, p, i;
        logic [31:0] rest;
        per  = s + g;
        p    = kk % (8 * per);
        i    = p / per;
        o.fd = (kk != 0) && (p == 0);
        if ((p % per) < s) begin
            o.an  = ~(8'd1 << i);
            rest  = sv >> (4 * i);
            o.seg = HEX_TAB[rest[3:0]];
`ifdef GPIO_DISP_LZB_EN
            if (i != 0 && rest == 32'd0) o.seg = 7'h7F;
`endif
            o.dp = ~sd[i];
        end else begin
            o.an  = 8'hFF;
            o.seg = 7'h7F;
            o.dp  = 1'b1;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic compare_all();
        obs_t e;
        e = q1.pop_front();
        chk("an",  {24'd0, bus1.an},  {24'd0, e.an});
        chk("seg", {25'd0, bus1.seg}, {25'd0, e.seg});
        chk("dp",  {31'd0, bus1.dp},  {31'd0, e.dp});
        chk("frame_done", {31'd0, bus1.frame_done}, {31'd0, e.fd});
        e = q0.pop_front();
        chk("an_nogap",  {24'd0, bus0.an},  {24'd0, e.an});
        chk("seg_nogap", {25'd0, bus0.seg}, {25'd0, e.seg});
        chk("dp_nogap",  {31'd0, bus0.dp},  {31'd0, e.dp});
        chk("frame_done_nogap", {31'd0, bus0.frame_done}, {31'd0, e.fd});
    endtask

    task automatic restart_check();
        k   = 0;
        sv1 = '0; sd1 = '0; sv0 = '0; sd0 = '0;
        q1.push_back(model(0, 4, 1, sv1, sd1));
        q0.push_back(model(0, 4, 0, sv0, sd0));
        compare_all();
    endtask

    // One clock: predict the next cycle, let the DUT step, then score it
    task automatic cycle();
        if ((k + 1) % 40 == 0) begin sv1 = value; sd1 = dp_mask; end
        if ((k + 1) % 32 == 0) begin sv0 = value; sd0 = dp_mask; end
        q1.push_back(model(k + 1, 4, 1, sv1, sd1));
        q0.push_back(model(k + 1, 4, 0, sv0, sd0));
        @(posedge clk);
        #1;
        k++;
        compare_all();
    endtask

    task automatic run_until(input int unsigned pos);
        cycle();
        while (k % 40 != pos) cycle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        restart_check();
        chk("shadow_rst", dut.shadow_val, 32'd0);
        rst = 1'b1;
        #1;
        restart_check();

        repeat (45) cycle();

        value   = 32'h89ABCDEF;
        dp_mask = 8'h01;
        repeat (80) cycle();

        run_until(39);
        value   = 32'h11111111;
        dp_mask = 8'h00;
        run_until(20);
        value = 32'h22222222;
        run_until(0);
        value = 32'h33333333;
        run_until(10);
        value = 32'h44444444;
        cycle();
        value = 32'h33333333;
        run_until(0);
        repeat (45) cycle();

        run_until(23);
        #1;
        rst = 1'b0;
        #1;
        restart_check();
        chk("shadow_midreset", dut.shadow_val, 32'd0);
        @(posedge clk);
        #1;
        restart_check();
        rst = 1'b1;
        #1;
        restart_check();
        repeat (45) cycle();

        value   = 32'h000000A5;
        dp_mask = 8'h84;
        repeat (80) cycle();
        value   = 32'h00000000;
        dp_mask = 8'h00;
        repeat (80) cycle();

        chk("queue_drained", q1.size() + q0.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_hex_display.md
# gpio_hex_display

- Consumer end of the CPU's 32-bit `gpio_out` port.
- Latches the word the CPU writes and shows it as eight hexadecimal digits on a multiplexed, common-anode seven-segment display.
- Display updates are frame-consistent: a new word or decimal-point mask is adopted only at a frame boundary, so the display never tears mid-scan.
- Sits at the board top level, between the `cpu` instance and the display pins.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit is lit (≥1).
- `GAP_CYC`, default 16: all-anodes-off cycles after each digit, for anti-ghosting (≥0; 0 means no gap).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `value` input 32: word to display; connected to CPU `gpio_out`; digit i shows `value[4i+3:4i]`.
- `dp_mask` input 8: bit i set lights the decimal point of digit i.
- `seg` output 7: segments a..g at bits 0..6, active-low.
- `dp` output 1: decimal point, active-low.
- `an` output 8: digit anodes, active-low; at most one bit low at any time.
- `frame_done` output 1: one-cycle pulse on the cycle the shadow registers reload.

## Operation
- Shadow registers hold the displayed data: `shadow_val` (32 bits) and `shadow_dp` (8 bits). The display decodes only these, never the live `value` or `dp_mask`.
- State machine:
  - States: SCAN and GAP.
  - Registers: digit index `dig` (3 bits) and cycle counter `cnt` (width $clog2 of max(SCAN_DIV, GAP_CYC, 1)).
- SCAN:
  - `an` = ~(1<<dig), `seg`/`dp` from digit `dig`.
  - When `cnt`==SCAN_DIV-1: clear `cnt`; go to GAP if GAP_CYC>0, otherwise advance directly.
- GAP:
  - `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - When `cnt`==GAP_CYC-1: clear `cnt` and advance.
- Advance:
  - `dig` wraps 7→0; state becomes SCAN.
  - On the 7→0 wrap, `shadow_val`←`value` and `shadow_dp`←`dp_mask` (the values sampled that cycle), and `frame_done` pulses.
- Hex decode (active-low, g..a order):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- All outputs are registered. Output values are computed from next-state values, so `an`/`seg` change on the same edge as the state.
- Reset (asynchronous, any time, including mid-frame):
  - `dig`=0, `cnt`=0, state SCAN, `shadow_val`=0, `shadow_dp`=0.
  - Outputs: `an`=8'hFE, `seg`=7'b1000000, `dp`=1, `frame_done`=0.
  - After reset release, scanning restarts at digit 0 with a full SCAN_DIV dwell.

## Timing
- Frame length F = 8·(SCAN_DIV+GAP_CYC) cycles.
- Digit i is lit during cycles [i·(SCAN_DIV+GAP_CYC), i·(SCAN_DIV+GAP_CYC)+SCAN_DIV) of each frame.
- Update latency: a change on `value` is displayed at most F cycles later, and no earlier than the next frame start.
- A `value` change on the exact wrap cycle is captured in that frame. A change one cycle later waits a full frame.
- `frame_done` is high for exactly one cycle per frame, coincident with `an` going to 8'hFE.
- Only the wrap-cycle sample is used; intermediate `value` glitches are ignored.

## Configuration
- `GPIO_DISP_LZB_EN` defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble of `shadow_val` show `seg`=7'h7F.
  - Their anode still cycles and their `dp` is still honoured.
  - Digit 0 is never blanked, so `value`=0 shows a single "0".
- `GPIO_DISP_LZB_EN` undefined: all eight digits are always shown, including leading zeros.

## Structure
- Package `gpio_disp_pkg` holds:
  - the state enum `disp_state_t` (SCAN, GAP);
  - localparam `SEG_BLANK`=7'h7F;
  - the 16-entry hex segment constant table.
- Sub-module `hex7seg`: combinational nibble→active-low segment decoder. It is instantiated once and fed the nibble muxed by next `dig`.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, GAP_CYC=1, so F=40.
- Reset release with `value`=0:
  - `an`=FE, `seg`=1000000 for 4 cycles, then `an`=FF for 1 cycle, then `an`=FD.
  - `frame_done` first pulses at cycle 40.
- `value`=32'h89ABCDEF with `dp_mask`=8'h01 held:
  - In the second frame the digits show F,E,d,C,b,A,9,8 (`seg` 0001110, 0000110, 0100001, 1000110, 0000011, 0001000, 0010000, 0000000).
  - `dp`=0 only while `an`=FE.
- `value` changed mid-frame (cycle 20, from 32'h11111111 to 32'h22222222):
  - Digits 4–7 of the current frame still show "1".
  - "2" appears from cycle 40.
- GAP_CYC=0 variant: `an` steps FE→FD→…→7F→FE every 4 cycles with no FF cycles.
- `rst` asserted at cycle 23, while digit 4 is lit:
  - Immediately `an`=FE, `seg`=1000000, `shadow_val`=0, `frame_done`=0.
  - After release, scanning restarts at digit 0.
- `GPIO_DISP_LZB_EN` defined, `value`=32'h000000A5:
  - Digits 0–1 show 5 and A.
  - Digits 2–7 show `seg`=7F with their anodes still cycling.
  - With `value`=0, only digit 0 shows "0".
